// File: rtl/data_mem_resp.sv
// Multi-cycle data memory for the MEM stage: a 64x32 word array behind an
// IDLE/BUSY/RESP handshake that stalls the pipeline until the access completes.
module data_mem_resp (
  input  logic        clk,
  input  logic        rst,
  input  logic        read_mem_MEM,
  input  logic        wite_mem_MEM,
  input  logic [31:0] addr_MEM,
  input  logic [31:0] wdata_MEM,
  output logic [31:0] rdata_MEM,
  output logic        mem_stall,
  output logic        mem_done,
  output logic        addr_err
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  typedef struct packed {
    logic        wr;
    logic        rd;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  state_t      state;
  req_t        req_q;
  logic [31:0] mem [64];

  logic       req_present;
  logic       in_range;
  logic       misaligned;
  logic [5:0] idx;

  assign req_present = read_mem_MEM | wite_mem_MEM;
  assign in_range    = (req_q.addr[31:8] == 24'd0);
  assign misaligned  = (req_q.addr[1:0] != 2'd0);
  assign idx         = req_q.addr[7:2];

  // Stall must see the request in the same cycle it arrives, so it stays combinational.
  assign mem_stall = ((state == IDLE) && req_present) || (state == BUSY);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      req_q     <= '0;
      rdata_MEM <= 32'd0;
      mem_done  <= 1'b0;
      addr_err  <= 1'b0;
    end else begin
      mem_done <= 1'b0;
      addr_err <= 1'b0;
      case (state)
        IDLE: begin
          if (req_present) begin
            req_q.wr    <= wite_mem_MEM;
            req_q.rd    <= read_mem_MEM;
            req_q.addr  <= addr_MEM;
            req_q.wdata <= wdata_MEM;
            state       <= BUSY;
          end
        end
        BUSY: begin
          // A simultaneous read/write is treated as a write; rdata is left alone.
          if (req_q.rd && !req_q.wr)
            rdata_MEM <= in_range ? mem[idx] : 32'd0;
          mem_done <= 1'b1;
          addr_err <= !in_range || misaligned;
          state    <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Array has no reset; a reset landing in BUSY blocks the commit.
  always_ff @(posedge clk) begin
    if (!rst && (state == BUSY) && req_q.wr && in_range)
      mem[idx] <= req_q.wdata;
  end

endmodule

// File: tb/tb_data_mem_resp.sv
// Transaction-level model of the data memory checked every cycle against the DUT,
// plus literal expectations on read-back data.
module tb_data_mem_resp;

  logic        clk;
  logic        rst;
  logic        read_mem_MEM;
  logic        wite_mem_MEM;
  logic [31:0] addr_MEM;
  logic [31:0] wdata_MEM;
  logic [31:0] rdata_MEM;
  logic        mem_stall;
  logic        mem_done;
  logic        addr_err;

  data_mem_resp dut (
    .clk(clk), .rst(rst),
    .read_mem_MEM(read_mem_MEM), .wite_mem_MEM(wite_mem_MEM),
    .addr_MEM(addr_MEM), .wdata_MEM(wdata_MEM),
    .rdata_MEM(rdata_MEM), .mem_stall(mem_stall),
    .mem_done(mem_done), .addr_err(addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // model state
  logic [31:0] mm [64];
  logic [31:0] m_rdata;
  logic        exp_stall, exp_done, exp_err;
  logic        chk_en;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("mem_stall", {31'd0, mem_stall}, {31'd0, exp_stall});
      check("mem_done",  {31'd0, mem_done},  {31'd0, exp_done});
      check("addr_err",  {31'd0, addr_err},  {31'd0, exp_err});
      check("rdata_MEM", rdata_MEM, m_rdata);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    read_mem_MEM = 1'b0;
    wite_mem_MEM = 1'b0;
    exp_stall = 1'b0; exp_done = 1'b0; exp_err = 1'b0;
    step();
  endtask

  // One 3-cycle access. glitch scrambles the inputs after the request is taken.
  // Returns at the start of the following cycle with inputs still driven.
  task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input logic glitch);
    logic inr;
    read_mem_MEM = rd; wite_mem_MEM = wr; addr_MEM = a; wdata_MEM = d;
    exp_stall = 1'b1; exp_done = 1'b0; exp_err = 1'b0;
    step();
    if (glitch) begin
      read_mem_MEM = 1'b1; wite_mem_MEM = 1'b1;
      addr_MEM = a ^ 32'h0000_0004; wdata_MEM = ~d;
    end
    step();
    inr = (a[31:8] == 24'd0);
    if (wr) begin
      if (inr) mm[a[7:2]] = d;
    end else if (rd) begin
      m_rdata = inr ? mm[a[7:2]] : 32'd0;
    end
    exp_stall = 1'b0; exp_done = 1'b1;
    exp_err = !inr || (a[1:0] != 2'd0);
    step();
  endtask

  initial begin
    chk_en = 1'b0;
    m_rdata = 32'd0;
    for (int i = 0; i < 64; i++) mm[i] = 32'd0;
    rst = 1'b1;
    read_mem_MEM = 1'b0; wite_mem_MEM = 1'b0;
    addr_MEM = 32'd0; wdata_MEM = 32'd0;
    exp_stall = 1'b0; exp_done = 1'b0; exp_err = 1'b0;
    step();
    chk_en = 1'b1;
    step();
    check("reset_rdata", rdata_MEM, 32'd0);
    rst = 1'b0;
    step();

    // write then read 0x10
    access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0); idle();
    access(1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
    check("read_0x10", rdata_MEM, 32'hDEADBEEF);
    idle();

    // read+write together: write wins
    access(1'b1, 1'b1, 32'h20, 32'h12345678, 1'b0);
    check("rw_rdata_kept", rdata_MEM, 32'hDEADBEEF);
    idle();
    access(1'b1, 1'b0, 32'h20, 32'h0, 1'b0);
    check("word8", rdata_MEM, 32'h12345678);
    idle();

    // out of range read/write
    access(1'b0, 1'b1, 32'h0, 32'hCAFE0000, 1'b0); idle();
    access(1'b1, 1'b0, 32'h100, 32'h0, 1'b0);
    check("oor_read", rdata_MEM, 32'd0);
    idle();
    access(1'b0, 1'b1, 32'h100, 32'hFFFFFFFF, 1'b0); idle();
    access(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
    check("oor_write_suppressed", rdata_MEM, 32'hCAFE0000);
    idle();

    // misaligned write lands on word 4
    access(1'b0, 1'b1, 32'h13, 32'hAAAA5555, 1'b0); idle();
    access(1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
    check("word4", rdata_MEM, 32'hAAAA5555);
    idle();
    access(1'b1, 1'b0, 32'h22, 32'h0, 1'b0);
    check("misaligned_read", rdata_MEM, 32'h12345678);
    idle();

    // reset during BUSY blocks the write
    access(1'b0, 1'b1, 32'h04, 32'h11111111, 1'b0); idle();
    read_mem_MEM = 1'b0; wite_mem_MEM = 1'b1; addr_MEM = 32'h04; wdata_MEM = 32'h1;
    exp_stall = 1'b1; exp_done = 1'b0; exp_err = 1'b0;
    step();
    rst = 1'b1; wite_mem_MEM = 1'b0;
    step();
    rst = 1'b0;
    m_rdata = 32'd0;
    exp_stall = 1'b0;
    step();
    check("rst_rdata", rdata_MEM, 32'd0);
    access(1'b1, 1'b0, 32'h04, 32'h0, 1'b0);
    check("word1_kept", rdata_MEM, 32'h11111111);

    // back-to-back reads, no idle gap
    access(1'b1, 1'b0, 32'h00, 32'h0, 1'b0);
    check("b2b_0", rdata_MEM, 32'hCAFE0000);
    access(1'b1, 1'b0, 32'h04, 32'h0, 1'b0);
    check("b2b_1", rdata_MEM, 32'h11111111);
    idle();

    // inputs changing mid-access must not affect the latched request
    access(1'b0, 1'b1, 32'h28, 32'h00000055, 1'b1); idle();
    access(1'b1, 1'b0, 32'h28, 32'h0, 1'b0);
    check("latched_write", rdata_MEM, 32'h00000055);
    idle();
    access(1'b1, 1'b0, 32'h2C, 32'h0, 1'b0);
    check("no_glitch_write", rdata_MEM, 32'd0);
    idle();
    idle();

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_resp.md
DATA_MEM_RESP -- requirements
Module: data_mem_resp

Interface
REQ-001 The block SHALL have one clock and one reset: reset is synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock shared with the IF/ID/EX/MEM/WB pipeline registers.
REQ-003 rst  input  1  synchronous active-high reset, sampled on posedge clk.
REQ-004 read_mem_MEM  input  1  load request from the MEM stage; held stable by the pipeline while mem_stall=1.
REQ-005 wite_mem_MEM  input  1  store request from the MEM stage; held stable while mem_stall=1.
REQ-006 addr_MEM  input  32  byte address (ALU0_MEM).
REQ-007 wdata_MEM  input  32  store data.
REQ-008 rdata_MEM  output  32  load data, feeds read_mem_data_MEM of the MEM/WB register.
REQ-009 mem_stall  output  1  freezes PC, IF/ID, ID/EX, EX/MEM; MEM/WB inserts a bubble.
REQ-010 mem_done  output  1  one-cycle pulse, access complete.
REQ-011 addr_err  output  1  one-cycle pulse with mem_done, access was misaligned or out of range.

Function
REQ-012 The block SHALL contain a 64 x 32-bit word array indexed by addr[7:2].
REQ-013 FSM states SHALL be IDLE, BUSY, RESP; encoding free.
REQ-014 IDLE: if read_mem_MEM or wite_mem_MEM is 1 -> latch addr, wdata, op; next state BUSY; else stay IDLE.
REQ-015 BUSY: perform array access on latched values; next state RESP unconditionally.
REQ-016 RESP: mem_done=1; next state IDLE unconditionally.
REQ-017 mem_stall SHALL be combinational: 1 in IDLE when a request is present, 1 in BUSY, 0 in RESP and idle IDLE.
REQ-018 Latency: request seen cycle N -> mem_stall high cycles N, N+1 -> rdata_MEM valid and mem_done=1 in cycle N+2; pipeline advances at end of N+2.
REQ-019 Request in IDLE one cycle after RESP SHALL be treated as new (next instruction); back-to-back accesses cost 3 cycles each.
REQ-020 Write: array word updated at end of BUSY cycle; rdata_MEM unchanged.
REQ-021 Read: rdata_MEM register loaded at end of BUSY; holds value until next completed read.
REQ-022 Both requests high: write wins, read ignored, rdata_MEM unchanged.
REQ-023 Out of range (addr[31:8] != 0): write suppressed, rdata_MEM loaded with 0, addr_err=1 in RESP.
REQ-024 Misaligned (addr[1:0] != 0): access proceeds on word addr[7:2], addr_err=1 in RESP.
REQ-025 Requests arriving in BUSY or RESP SHALL NOT start a new access or alter latched values.

Reset
REQ-026 rst=1 SHALL force state IDLE, rdata_MEM=0, mem_done=0, addr_err=0; mem_stall then follows REQ-017.
REQ-027 rst SHALL take priority over all transitions; a write in BUSY with rst=1 SHALL NOT commit.
REQ-028 Array contents SHALL NOT be cleared by rst.

Verification
REQ-029 Write 0xDEADBEEF to 0x10, then read 0x10 -> stall high 2 cycles each, rdata_MEM=0xDEADBEEF with mem_done on read's 3rd cycle.
REQ-030 Read and write both high, addr 0x20, wdata 0x12345678 -> word 8 = 0x12345678, rdata_MEM unchanged.
REQ-031 Read 0x100 -> rdata_MEM=0, addr_err=1 with mem_done; write 0x100 -> no array word changes.
REQ-032 Write 0xAAAA5555 to 0x13 -> addr_err=1, word 4 = 0xAAAA5555.
REQ-033 Write 0x1 to 0x04, rst=1 during BUSY -> word 1 unchanged, state IDLE, outputs 0 next cycle.
REQ-034 Reads of 0x00 and 0x04 on consecutive instructions -> each completes in 3 cycles, no dropped or duplicated access.
